// File: rtl/apu_multichannel.sv
// rtl/apu_multichannel.sv - multi-voice square/saw/noise synth with release envelope and sigma-delta output
// Pitch advances on raster line ticks, duration and envelope on frame ticks.
module apu_multichannel #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 10,
    parameter int DUR_W    = 6,
    parameter int AMP_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         trigger,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [PERIOD_W*NUM_CH-1:0] period,
    input  logic [DUR_W*NUM_CH-1:0]   duration,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic                      sound,
    output logic [NUM_CH-1:0]         active
);
    localparam int S     = AMP_W + $clog2(NUM_CH);
    localparam int ATT_W = $clog2(AMP_W) + 1;

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    logic line_tick, frame_tick;
    assign line_tick  = (x == 10'd0);
    assign frame_tick = line_tick && (y == 10'd0);

    logic [AMP_W-1:0] voice_lvl [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        state_t              state_q, state_d;
        logic [1:0]          mode_q, mode_d;
        logic [PERIOD_W-1:0] period_q, period_d, phase_q, phase_d, last_phase;
        logic [DUR_W-1:0]    dur_q, dur_d;
        logic [ATT_W-1:0]    atten_q, atten_d;
        logic                sq_q, sq_d, act_q;
        logic [AMP_W-1:0]    saw_q, saw_d, wave;
        logic [14:0]         lfsr_q, lfsr_d;
        logic [1:0]          trig_mode;

        assign trig_mode  = mode[2*i +: 2];
        // A zero period behaves like one: step on every line tick.
        assign last_phase = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

        always_comb begin
            state_d  = state_q;
            mode_d   = mode_q;
            period_d = period_q;
            phase_d  = phase_q;
            dur_d    = dur_q;
            atten_d  = atten_q;
            sq_d     = sq_q;
            saw_d    = saw_q;
            lfsr_d   = lfsr_q;
            if (trigger[i]) begin
                if (trig_mode == 2'b11) begin
                    state_d = IDLE;
                end else begin
                    mode_d   = trig_mode;
                    period_d = period[PERIOD_W*i +: PERIOD_W];
                    dur_d    = duration[DUR_W*i +: DUR_W];
                    phase_d  = '0;
                    atten_d  = '0;
                    sq_d     = 1'b0;
                    saw_d    = '0;
                    state_d  = (duration[DUR_W*i +: DUR_W] == '0) ? RELEASE : PLAY;
                end
            end else if (state_q != IDLE) begin
                if (line_tick) begin
                    if (phase_q >= last_phase) begin
                        phase_d = '0;
                        case (mode_q)
                            2'b00:   sq_d   = ~sq_q;
                            2'b01:   saw_d  = saw_q + AMP_W'(1);
                            default: lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                        endcase
                    end else begin
                        phase_d = phase_q + PERIOD_W'(1);
                    end
                end
                if (frame_tick) begin
                    if (state_q == PLAY) begin
                        dur_d = dur_q - DUR_W'(1);
                        if (dur_q == DUR_W'(1)) begin
                            state_d = RELEASE;
                            atten_d = ATT_W'(1);
                        end
                    end else if (atten_q == ATT_W'(AMP_W-1)) begin
                        state_d = IDLE;
                    end else begin
                        atten_d = atten_q + ATT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= IDLE;
                mode_q   <= 2'b00;
                period_q <= '0;
                phase_q  <= '0;
                dur_q    <= '0;
                atten_q  <= '0;
                sq_q     <= 1'b0;
                saw_q    <= '0;
                lfsr_q   <= 15'(i + 1);
                act_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                mode_q   <= mode_d;
                period_q <= period_d;
                phase_q  <= phase_d;
                dur_q    <= dur_d;
                atten_q  <= atten_d;
                sq_q     <= sq_d;
                saw_q    <= saw_d;
                lfsr_q   <= lfsr_d;
                act_q    <= (state_d != IDLE);
            end
        end

        always_comb begin
            case (mode_q)
                2'b00:   wave = sq_q ? {AMP_W{1'b1}} : '0;
                2'b01:   wave = saw_q;
                default: wave = lfsr_q[AMP_W-1:0];
            endcase
        end

        assign voice_lvl[i] = (state_q == IDLE) ? '0 : (wave >> atten_q);
        assign active[i]    = act_q;
    end

    logic [S-1:0] sum, acc_q;
    logic [S:0]   mix;
    logic         sound_q;

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_CH; k++) sum = sum + S'(voice_lvl[k]);
    end

    // First-order sigma-delta: the accumulator carry is the output bit.
    assign mix = {1'b0, acc_q} + {1'b0, sum};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            sound_q <= 1'b0;
        end else begin
            acc_q   <= mix[S-1:0];
            sound_q <= mix[S];
        end
    end

    assign sound = sound_q;
endmodule

// File: tb/tb_apu_multichannel.sv
// tb/tb_apu_multichannel.sv - randomized and directed bench for apu_multichannel against a behavioural voice model
module tb_apu_multichannel;
    localparam int NCH = 4, PW = 10, DW = 6, AW = 4, S = 6, XW = 8, YH = 4;

    logic clk = 1'b0;
    logic reset;
    logic [NCH-1:0] trigger;
    logic [2*NCH-1:0] mode;
    logic [PW*NCH-1:0] period;
    logic [DW*NCH-1:0] duration;
    logic [9:0] x, y;
    logic sound;
    logic [NCH-1:0] active;

    int tmode[NCH], tper[NCH], tdur[NCH];
    int n_cmp = 0, n_bad = 0;

    // behavioural voice state: st 0 idle / 1 play / 2 release
    int st[NCH], ph[NCH], du[NCH], at[NCH], sqv[NCH], sw[NCH], lf[NCH], pr[NCH], md[NCH];
    int acc_m, snd_m;

    apu_multichannel #(.NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW), .AMP_W(AW)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .mode(mode), .period(period),
        .duration(duration), .x(x), .y(y), .sound(sound), .active(active)
    );

    always #5 clk = ~clk;

    always_comb begin
        mode = '0;
        period = '0;
        duration = '0;
        for (int i = 0; i < NCH; i++) begin
            mode[2*i +: 2]       = 2'(tmode[i]);
            period[PW*i +: PW]   = PW'(tper[i]);
            duration[DW*i +: DW] = DW'(tdur[i]);
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int level_of(int i);
        int w;
        if (st[i] == 0) return 0;
        case (md[i])
            0:       w = sqv[i] ? (1 << AW) - 1 : 0;
            1:       w = sw[i];
            default: w = lf[i] % (1 << AW);
        endcase
        return w >> at[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            st[i] = 0; ph[i] = 0; du[i] = 0; at[i] = 0; sqv[i] = 0;
            sw[i] = 0; lf[i] = i + 1; pr[i] = 0; md[i] = 0;
        end
        acc_m = 0;
        snd_m = 0;
    endtask

    task automatic model_step();
        int sum, t, lim;
        bit lt, ft;
        sum = 0;
        for (int i = 0; i < NCH; i++) sum += level_of(i);
        t = acc_m + sum;
        snd_m = (t >= (1 << S)) ? 1 : 0;
        acc_m = t % (1 << S);
        lt = (x == 0);
        ft = lt && (y == 0);
        for (int i = 0; i < NCH; i++) begin
            if (trigger[i] && tmode[i] == 3) begin
                st[i] = 0;
            end else if (trigger[i]) begin
                md[i] = tmode[i]; pr[i] = tper[i]; du[i] = tdur[i];
                ph[i] = 0; sqv[i] = 0; sw[i] = 0; at[i] = 0;
                st[i] = (tdur[i] == 0) ? 2 : 1;
            end else if (st[i] != 0) begin
                if (lt) begin
                    lim = ((pr[i] == 0) ? 1 : pr[i]) - 1;
                    if (ph[i] >= lim) begin
                        ph[i] = 0;
                        if (md[i] == 0) sqv[i] = 1 - sqv[i];
                        else if (md[i] == 1) sw[i] = (sw[i] + 1) % (1 << AW);
                        else lf[i] = ((lf[i] << 1) % 32768) | (((lf[i] >> 14) ^ (lf[i] >> 13)) & 1);
                    end else begin
                        ph[i]++;
                    end
                end
                if (ft) begin
                    if (st[i] == 1) begin
                        du[i]--;
                        if (du[i] == 0) begin st[i] = 2; at[i] = 1; end
                    end else if (at[i] == AW - 1) begin
                        st[i] = 0;
                    end else begin
                        at[i]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        int a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        a = 0;
        for (int i = 0; i < NCH; i++) if (st[i] != 0) a |= (1 << i);
        check("active", 32'(active), 32'(a));
        check("sound", 32'(sound), 32'(snd_m));
        trigger = '0;
        if (x == XW - 1) begin
            x = 0;
            y = (y == YH - 1) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
    endtask

    task automatic wait_at(int xt, int yt);
        for (int c = 0; c < XW * YH + 1; c++) begin
            if (x == xt && y == yt) return;
            tick();
        end
    endtask

    task automatic frames_to_idle(int ch, output int frames);
        bit ft;
        frames = 0;
        for (int c = 0; c < 600; c++) begin
            ft = (x == 0 && y == 0);
            tick();
            if (ft) frames++;
            if (!active[ch]) return;
        end
        frames = -1;
    endtask

    task automatic fire(int ch, int m, int p, int d);
        tmode[ch] = m; tper[ch] = p; tdur[ch] = d;
        trigger[ch] = 1'b1;
    endtask

    task automatic random_run(int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    fire(i, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                         $urandom_range(0, 4), $urandom_range(0, 3));
                end
            end
            tick();
        end
    endtask

    initial begin
        int fr, gap, ftc;
        bit ft;
        reset = 1'b1;
        trigger = '0;
        x = 10'd1;
        y = 10'd0;
        for (int i = 0; i < NCH; i++) begin tmode[i] = 0; tper[i] = 0; tdur[i] = 0; end
        model_reset();
        #12;
        check("reset_sound", 32'(sound), 0);
        check("reset_active", 32'(active), 0);
        @(negedge clk);
        reset = 1'b0;

        // square, period 2, duration 3: three sustain frames plus three release frames
        wait_at(3, 1);
        fire(0, 0, 2, 3);
        tick();
        check("sq_active_rise", 32'(active[0]), 1);
        frames_to_idle(0, fr);
        check("sq_frames_to_idle", 32'(fr), 6);

        // noise on ch1 and saw on ch2 with period 1, sustained together
        wait_at(2, 2);
        fire(1, 2, 1, 3);
        fire(2, 1, 1, 3);
        tick();
        for (int c = 0; c < 40; c++) tick();

        // retrigger ch0 two frames into a three-frame note
        wait_at(3, 1);
        fire(0, 0, 2, 3);
        tick();
        ftc = 0;
        gap = 0;
        for (int c = 0; c < 200 && ftc < 2; c++) begin
            ft = (x == 0 && y == 0);
            tick();
            if (ft) ftc++;
            if (!active[0]) gap = 1;
        end
        fire(0, 0, 2, 3);
        tick();
        if (!active[0]) gap = 1;
        check("retrig_nogap", 32'(gap), 0);
        frames_to_idle(0, fr);
        check("retrig_frames_to_idle", 32'(fr), 6);

        // trigger on a frame tick: duration 1 must not be consumed by that tick
        wait_at(0, 0);
        fire(2, 1, 1, 1);
        tick();
        check("frame_trig_active", 32'(active[2]), 1);
        frames_to_idle(2, fr);
        check("frame_trig_frames", 32'(fr), 4);

        // kill a playing voice
        wait_at(4, 1);
        fire(3, 0, 1, 5);
        tick();
        for (int c = 0; c < 20; c++) tick();
        check("kill_pre", 32'(active[3]), 1);
        fire(3, 3, 0, 0);
        tick();
        check("kill_idle", 32'(active[3]), 0);
        for (int c = 0; c < 20; c++) tick();

        random_run(2500);

        // asynchronous reset mid-note
        fire(0, 0, 1, 3);
        fire(1, 1, 1, 3);
        tick();
        for (int c = 0; c < 30; c++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset_sound", 32'(sound), 0);
        check("midreset_active", 32'(active), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        check("post_reset_idle", 32'(active), 0);

        random_run(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apu_multichannel.md
Name: apu_multichannel

Overview:
- Parametrised successor to the single-voice AudioProcessingUnit: NUM_CH independent voices, each selectable as square, saw or noise.
- Each voice has a programmable pitch period, note duration and a release envelope.
- Voices are summed and converted to a 1-bit sigma-delta `sound` output for the board's audio pin.
- Pitch is timed from VGA line ticks and duration/envelope from frame ticks, both derived from the raster coordinates x/y. The block sits beside the PPU and shares its pixel clock.

Parameters:
- NUM_CH, 4, number of voices (1..8).
- PERIOD_W, 10, width of per-voice pitch period, in line ticks.
- DUR_W, 6, width of per-voice note duration, in frames.
- AMP_W, 4, per-voice sample amplitude width.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  NUM_CH  1-cycle pulse per voice; starts or retriggers a note.
- mode  in  2*NUM_CH  per voice, voice i at [2i+1:2i]: 00 square, 01 saw, 10 noise, 11 kill.
- period  in  PERIOD_W*NUM_CH  per-voice pitch period, sampled on trigger.
- duration  in  DUR_W*NUM_CH  per-voice sustain length in frames, sampled on trigger.
- x  in  10  current raster column.
- y  in  10  current raster row.
- sound  out  1  registered sigma-delta audio bit.
- active  out  NUM_CH  registered; voice i is not IDLE.

Behaviour:
- Tick decode (combinational, not registered):
  - line_tick = (x==0).
  - frame_tick = (x==0 && y==0).
- Per-voice FSM states: IDLE, PLAY, RELEASE.
- Trigger with mode≠11, in any state:
  - latch mode, period and duration;
  - phase=0, wave=0, atten=0;
  - enter PLAY, or RELEASE if duration==0.
  - active[i]=1 on the next cycle.
- Trigger with mode==11: enter IDLE next cycle (kill).
- PLAY:
  - On line_tick the phase counter increments.
  - When phase ≥ max(period,1)-1, phase wraps to 0 and the waveform steps.
  - On frame_tick the duration counter decrements; on the tick where it reaches 0, enter RELEASE with atten=1.
- Waveform step:
  - square: toggles bit sq; level = sq ? 2^AMP_W-1 : 0.
  - saw: saw += 1 mod 2^AMP_W; level = saw.
  - noise: 15-bit Fibonacci LFSR, taps 15,14, shifts left, feedback = bit14^bit13; level = lfsr[AMP_W-1:0].
- RELEASE:
  - The waveform keeps stepping; output = level >> atten.
  - On frame_tick: if atten==AMP_W-1, go IDLE; else atten++.
  - RELEASE therefore lasts AMP_W-1 frames.
- IDLE: output level 0; counters hold.
- Priority: a trigger in the same cycle as a line_tick or frame_tick wins; the fresh duration is loaded un-decremented.
- Mixer:
  - sum = Σ voice outputs, width S = AMP_W+clog2(NUM_CH).
  - Each cycle {c, acc} <= acc + sum, where acc is S bits.
  - sound <= c, one cycle after sum changes.
  - Pulse density = sum/2^S.
- Reset (async; also applies mid-note):
  - all voices IDLE; phase, wave, duration and atten = 0;
  - LFSR of voice i = i+1;
  - acc=0, sound=0, active=0.
- LFSR is never zero: the seed is nonzero and retrigger does not reseed.
- Width rules:
  - period==0 is treated as 1, so the voice steps every line tick.
  - All counters wrap modulo their width.
  - The mixer sum never overflows S bits.

Test Plan:
- Reset asserted mid-note with sound toggling → within the same cycle sound=0 and active=0. After release, all channels stay idle until a trigger arrives.
- Ch0 square, period=2, duration=3, others idle → active[0] rises 1 cycle after trigger. The level alternates 15/0 every 2 line ticks, and sound density is 15/64 while high. RELEASE starts at the 3rd frame_tick and lasts 3 frames (levels 7, 3, 1). active[0] falls at the 6th frame_tick.
- Ch1 noise, period=1 → LFSR steps from 0x0002 to 0x0004 to 0x0008 on successive line ticks, so output levels are 2, 4, 8.
- Ch2 saw, period=1 → levels 1, 2, …, 15, 0 on consecutive line ticks.
- Retrigger ch0 at frame 2 of duration 3 → phase is reset and duration reloaded; active[0] stays high with no gap, and RELEASE starts 3 frames after the retrigger.
- Simultaneous trigger and frame_tick, then mode=11 trigger on a playing voice → first: duration is loaded as given, not decremented. Second: the voice goes IDLE next cycle, its level is 0, and sound density drops accordingly.
